// File: rtl/strip_pkg.sv
// Shared types and constants for the strip scheduler and strip controller.
package strip_pkg;

  localparam int unsigned BYTES_PER_LED = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_FLUSH_REQ,
    ST_FLUSHING,
    ST_LATCH
  } sched_state_t;

endpackage

// File: rtl/strip_scheduler_if.sv
// Requester-side bus of the strip scheduler: frame requests, byte writes, grants.
interface strip_scheduler_if;
  logic [1:0] req;
  logic [1:0] done;
  logic [1:0] wvalid;
  logic [7:0] wdata0;
  logic [7:0] wdata1;
  logic [7:0] waddr0;
  logic [7:0] waddr1;
  logic [1:0] gnt;
  logic [1:0] wready;

  // Requesters drive requests/writes and observe grants.
  modport master (
    output req, done, wvalid, wdata0, wdata1, waddr0, waddr1,
    input  gnt, wready
  );

  // The scheduler consumes requests/writes and drives grants.
  modport slave (
    input  req, done, wvalid, wdata0, wdata1, waddr0, waddr1,
    output gnt, wready
  );
endinterface

// File: rtl/strip_rr_arbiter.sv
// Two-way round-robin arbiter: the pointer holds the last-served index and the
// other requester wins a tie. Pointer resets to 1 so requester 0 wins first.
module strip_rr_arbiter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req_i,
  input  logic       update_i,
  input  logic       served_i,
  output logic       winner_o
);

  logic ptr_q;

  // Combinational pick from the current requests and pointer.
  always_comb begin
    winner_o = 1'b0;
    if (req_i == 2'b11) begin
      winner_o = ~ptr_q;
    end else if (req_i == 2'b10) begin
      winner_o = 1'b1;
    end
  end

  // Pointer records the requester just served when its frame ends.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= 1'b1;
    end else if (update_i) begin
      ptr_q <= served_i;
    end
  end

endmodule

// File: rtl/strip_scheduler.sv
// Frame-level scheduler in front of strip_controller: grants one requester per
// frame, forwards its byte writes, runs the flush handshake and enforces the
// latch gap before the next grant.
module strip_scheduler
  import strip_pkg::*;
#(
  parameter int unsigned NUM_BYTES    = BYTES_PER_LED,
  parameter int unsigned LATCH_CYCLES = 5000
) (
  input  logic                    clk,
  input  logic                    reset,
  strip_scheduler_if.slave        rq,
  output logic                    sc_write_en,
  output logic [7:0]              sc_write_data,
  output logic [7:0]              sc_write_addr,
  output logic                    sc_flush,
  input  logic                    sc_flushing,
  output logic                    busy,
  output logic [15:0]             frame_count,
  output logic                    err_addr
);

  localparam int unsigned CNT_W = (LATCH_CYCLES > 1) ? $clog2(LATCH_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATCH_CYCLES - 1);

  sched_state_t     state_q;
  logic             g_q;
  logic [1:0]       gnt_q;
  logic             busy_q;
  logic             we_q;
  logic [7:0]       wdata_q;
  logic [7:0]       waddr_q;
  logic             flush_q;
  logic [CNT_W-1:0] cnt_q;
  logic [15:0]      fc_q;
  logic             err_q;

  logic             winner;
  logic             arb_update;
  logic             g_wvalid;
  logic             g_done;
  logic             g_req;
  logic [7:0]       g_wdata;
  logic [7:0]       g_waddr;
  logic             addr_ok;

  // Select the grantee's lane and decide when the arbiter pointer moves.
  always_comb begin
    g_wvalid   = rq.wvalid[g_q];
    g_done     = rq.done[g_q];
    g_req      = rq.req[g_q];
    g_wdata    = g_q ? rq.wdata1 : rq.wdata0;
    g_waddr    = g_q ? rq.waddr1 : rq.waddr0;
    addr_ok    = 32'(g_waddr) < NUM_BYTES;
    arb_update = (state_q == ST_WRITE) && (g_done || !g_req);
  end

  strip_rr_arbiter u_arb (
    .clk      (clk),
    .rst_n    (reset),
    .req_i    (rq.req),
    .update_i (arb_update),
    .served_i (g_q),
    .winner_o (winner)
  );

  // Frame FSM with registered outputs, latch counter and frame counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      g_q     <= 1'b0;
      gnt_q   <= '0;
      busy_q  <= 1'b0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      waddr_q <= '0;
      flush_q <= 1'b0;
      cnt_q   <= '0;
      fc_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      we_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (rq.req != 2'b00) begin
            state_q <= ST_WRITE;
            g_q     <= winner;
            gnt_q   <= winner ? 2'b10 : 2'b01;
            busy_q  <= 1'b1;
          end
        end
        ST_WRITE: begin
          // wready mirrors gnt, so a grantee wvalid is always an accepted write.
          if (g_wvalid) begin
            if (addr_ok) begin
              we_q    <= 1'b1;
              wdata_q <= g_wdata;
              waddr_q <= g_waddr;
            end else begin
              err_q <= 1'b1;
            end
          end
          if (g_done) begin
            state_q <= ST_FLUSH_REQ;
            gnt_q   <= '0;
            flush_q <= 1'b1;
          end else if (!g_req) begin
            state_q <= ST_IDLE;
            gnt_q   <= '0;
            busy_q  <= 1'b0;
          end
        end
        ST_FLUSH_REQ: begin
          if (sc_flushing) begin
            state_q <= ST_FLUSHING;
            flush_q <= 1'b0;
          end
        end
        ST_FLUSHING: begin
          if (!sc_flushing) begin
            state_q <= ST_LATCH;
            cnt_q   <= CNT_LOAD;
            fc_q    <= fc_q + 16'd1;
          end
        end
        ST_LATCH: begin
          if (cnt_q == '0) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign rq.gnt        = gnt_q;
  assign rq.wready     = gnt_q;
  assign sc_write_en   = we_q;
  assign sc_write_data = wdata_q;
  assign sc_write_addr = waddr_q;
  assign sc_flush      = flush_q;
  assign busy          = busy_q;
  assign frame_count   = fc_q;
  assign err_addr      = err_q;

endmodule

// File: tb/tb_strip_scheduler.sv
// Bench for strip_scheduler: table-driven single frame, hand-written corner
// sequences, then randomized frames against a transaction-level model.
module tb_strip_scheduler;

  localparam int unsigned NB = 3;
  localparam int unsigned L  = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sc_write_en;
  logic [7:0]  sc_write_data;
  logic [7:0]  sc_write_addr;
  logic        sc_flush;
  logic        sc_flushing = 1'b0;
  logic        busy;
  logic [15:0] frame_count;
  logic        err_addr;

  strip_scheduler_if bus ();

  strip_scheduler #(
    .NUM_BYTES    (NB),
    .LATCH_CYCLES (L)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .rq            (bus),
    .sc_write_en   (sc_write_en),
    .sc_write_data (sc_write_data),
    .sc_write_addr (sc_write_addr),
    .sc_flush      (sc_flush),
    .sc_flushing   (sc_flushing),
    .busy          (busy),
    .frame_count   (frame_count),
    .err_addr      (err_addr)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_gnt(input int budget, output int n);
    n = 0;
    while (bus.gnt == 2'b00 && n < budget) begin
      tick();
      n++;
    end
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (busy && n < budget) begin
      tick();
      n++;
    end
    chk("idle_timeout", busy, 1'b0);
  endtask

  // Write monitor: records every forwarded write as {addr, data}.
  logic        mon_en = 1'b0;
  logic [15:0] got_q[$];
  logic [15:0] exp_q[$];

  always @(negedge clk) begin
    if (mon_en && sc_write_en) got_q.push_back({sc_write_addr, sc_write_data});
  end

  typedef struct {
    logic [1:0] wv;
    logic [7:0] a0, d0, a1, d1;
    logic       en;
    logic [7:0] ea, ed;
    logic       err;
  } vec_t;

  vec_t tbl[8];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    logic       exp_ptr;
    logic [15:0] exp_fc;
    logic       exp_err;

    tbl[0] = '{2'b01, 8'h00, 8'h11, 8'h00, 8'h00, 1'b1, 8'h00, 8'h11, 1'b0};
    tbl[1] = '{2'b01, 8'h01, 8'h22, 8'h00, 8'h00, 1'b1, 8'h01, 8'h22, 1'b0};
    tbl[2] = '{2'b01, 8'h02, 8'h33, 8'h00, 8'h00, 1'b1, 8'h02, 8'h33, 1'b0};
    tbl[3] = '{2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0};
    tbl[4] = '{2'b10, 8'h00, 8'h00, 8'h07, 8'h99, 1'b0, 8'h00, 8'h00, 1'b0};
    tbl[5] = '{2'b01, 8'h03, 8'h44, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b1};
    tbl[6] = '{2'b11, 8'h02, 8'h55, 8'h00, 8'hAA, 1'b1, 8'h02, 8'h55, 1'b1};
    tbl[7] = '{2'b10, 8'h00, 8'h00, 8'h01, 8'hBB, 1'b0, 8'h00, 8'h00, 1'b1};

    bus.req = '0; bus.done = '0; bus.wvalid = '0;
    bus.wdata0 = '0; bus.wdata1 = '0; bus.waddr0 = '0; bus.waddr1 = '0;

    // Reset values
    #2 reset = 1'b0;
    #1;
    chk("rst_gnt", bus.gnt, 2'b00);
    chk("rst_wready", bus.wready, 2'b00);
    chk("rst_we", sc_write_en, 1'b0);
    chk("rst_wdata", sc_write_data, 8'h00);
    chk("rst_waddr", sc_write_addr, 8'h00);
    chk("rst_flush", sc_flush, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_fc", frame_count, 16'd0);
    chk("rst_err", err_addr, 1'b0);
    tick(); tick();
    reset = 1'b1;
    tick();

    // Contention from reset: requester 0 wins first
    bus.req = 2'b11;
    tick();
    chk("first_gnt", bus.gnt, 2'b01);
    chk("first_wready", bus.wready, 2'b01);
    chk("first_busy", busy, 1'b1);

    // Table-driven writes: forwarded one cycle late, back-to-back
    for (int i = 0; i < 8; i++) begin
      bus.wvalid = tbl[i].wv;
      bus.waddr0 = tbl[i].a0; bus.wdata0 = tbl[i].d0;
      bus.waddr1 = tbl[i].a1; bus.wdata1 = tbl[i].d1;
      tick();
      chk($sformatf("tbl%0d_en", i), sc_write_en, tbl[i].en);
      if (tbl[i].en) begin
        chk($sformatf("tbl%0d_addr", i), sc_write_addr, tbl[i].ea);
        chk($sformatf("tbl%0d_data", i), sc_write_data, tbl[i].ed);
      end
      chk($sformatf("tbl%0d_err", i), err_addr, tbl[i].err);
    end

    // Write with done in the same cycle, done beats the req drop
    bus.wvalid = 2'b01; bus.waddr0 = 8'h00; bus.wdata0 = 8'h66;
    bus.done = 2'b01; bus.req = 2'b10;
    tick();
    chk("done_we", sc_write_en, 1'b1);
    chk("done_wdata", sc_write_data, 8'h66);
    chk("done_flush", sc_flush, 1'b1);
    chk("done_gnt", bus.gnt, 2'b00);
    bus.wvalid = '0; bus.done = '0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("flush_hold", sc_flush, 1'b1);
    end
    chk("flush_we_pulse", sc_write_en, 1'b0);
    sc_flushing = 1'b1;
    tick();
    chk("flush_fall", sc_flush, 1'b0);
    tick(); tick();
    chk("fc_during_flushing", frame_count, 16'd0);

    // Latch gap: gnt rises L+1 cycles after the edge that samples flushing low
    sc_flushing = 1'b0;
    tick();
    chk("fc_one", frame_count, 16'd1);
    wait_gnt(L + 10, n);
    chk("latch_gap", n, L + 1);
    chk("second_gnt", bus.gnt, 2'b10);

    // Requester 1 frame, both requesting afterwards -> back to requester 0
    bus.req = 2'b11;
    bus.wvalid = 2'b10; bus.waddr1 = 8'h01; bus.wdata1 = 8'h77;
    tick();
    chk("r1_we", sc_write_en, 1'b1);
    chk("r1_wdata", sc_write_data, 8'h77);
    bus.wvalid = '0; bus.done = 2'b10;
    tick();
    chk("r1_flush", sc_flush, 1'b1);
    bus.done = '0; sc_flushing = 1'b1;
    tick();
    sc_flushing = 1'b0;
    tick();
    wait_gnt(L + 10, n);
    chk("third_gnt", bus.gnt, 2'b01);
    chk("err_sticky", err_addr, 1'b1);
    chk("fc_two", frame_count, 16'd2);

    // Abort: grantee drops req mid-WRITE
    bus.req = 2'b10;
    tick();
    chk("abort_gnt", bus.gnt, 2'b00);
    chk("abort_busy", busy, 1'b0);
    chk("abort_flush", sc_flush, 1'b0);
    tick();
    chk("abort_regrant", bus.gnt, 2'b10);
    chk("abort_fc", frame_count, 16'd2);

    // Reset during FLUSHING
    bus.done = 2'b10;
    tick();
    bus.done = '0; sc_flushing = 1'b1;
    tick();
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_flush", sc_flush, 1'b0);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_gnt", bus.gnt, 2'b00);
    chk("mid_rst_fc", frame_count, 16'd0);
    chk("mid_rst_err", err_addr, 1'b0);
    chk("mid_rst_we", sc_write_en, 1'b0);
    bus.req = '0; sc_flushing = 1'b0;
    tick(); tick();
    reset = 1'b1;
    tick();
    chk("post_rst_busy", busy, 1'b0);
    bus.req = 2'b11;
    tick();
    chk("post_rst_gnt", bus.gnt, 2'b01);
    bus.req = '0;
    tick();
    chk("post_rst_abort", busy, 1'b0);

    // Randomized frames against a transaction-level model
    exp_ptr = 1'b0;
    exp_fc  = 16'd0;
    exp_err = 1'b0;
    mon_en  = 1'b1;
    for (int f = 0; f < 24; f++) begin
      int unsigned r;
      int unsigned nwr;
      logic        w;
      logic [1:0]  wv;
      logic [1:0]  rn;
      logic [7:0]  ga, gd;
      r = $urandom_range(1, 3);
      w = (r == 3) ? ~exp_ptr : (r == 2);
      bus.req = 2'(r);
      tick();
      chk("rand_gnt", bus.gnt, w ? 2'b10 : 2'b01);
      nwr = $urandom_range(0, 6);
      for (int k = 0; k < int'(nwr); k++) begin
        wv = 2'($urandom_range(0, 3));
        rn = 2'($urandom_range(0, 3));
        rn[w] = 1'b1;
        bus.req = rn;
        bus.wvalid = wv;
        bus.waddr0 = 8'($urandom_range(0, 4)); bus.wdata0 = 8'($urandom);
        bus.waddr1 = 8'($urandom_range(0, 4)); bus.wdata1 = 8'($urandom);
        ga = w ? bus.waddr1 : bus.waddr0;
        gd = w ? bus.wdata1 : bus.wdata0;
        if (wv[w]) begin
          if (ga < NB) exp_q.push_back({ga, gd});
          else exp_err = 1'b1;
        end
        tick();
      end
      bus.wvalid = '0;
      if ($urandom_range(0, 9) == 0) begin
        bus.req = '0;
        tick();
        chk("rand_abort_busy", busy, 1'b0);
        chk("rand_abort_flush", sc_flush, 1'b0);
      end else begin
        bus.done = w ? 2'b10 : 2'b01;
        bus.req = '0;
        tick();
        chk("rand_flush", sc_flush, 1'b1);
        bus.done = '0;
        repeat ($urandom_range(0, 3)) tick();
        sc_flushing = 1'b1;
        tick();
        chk("rand_flush_fall", sc_flush, 1'b0);
        repeat ($urandom_range(0, 3)) tick();
        sc_flushing = 1'b0;
        exp_fc = exp_fc + 16'd1;
        wait_idle(L + 6);
      end
      exp_ptr = w;
      chk("rand_fc", frame_count, exp_fc);
      chk("rand_err", err_addr, exp_err);
      chk("rand_wr_count", got_q.size(), exp_q.size());
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
        chk("rand_wr", got_q[i], exp_q[i]);
      end
      got_q.delete();
      exp_q.delete();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/strip_scheduler.md
# strip_scheduler

Frame-level scheduler sitting in front of `strip_controller`. Two requesters (host loader, pattern engine) compete for the strip's byte buffer; the scheduler grants one requester per frame, forwards its byte writes, issues the flush handshake when the frame is done, and enforces the WS2812 latch gap before the next grant. It is the only agent that drives `strip_controller`'s write and flush inputs.

## Interface
- `NUM_BYTES`, 3: valid buffer bytes (3 per LED); writes with `waddr >= NUM_BYTES` are dropped.
- `LATCH_CYCLES`, 5000: idle cycles after `sc_flushing` falls before the next grant (≥1).
- `clk`  in  1  system clock; one clock domain.
- `reset`  in  1  asynchronous, active-low reset.
- `req`  in  2  per-requester frame request (bit i = requester i).
- `done`  in  2  per-requester one-cycle "frame complete" pulse; honoured only from the grantee.
- `wvalid`  in  2  per-requester byte-write valid.
- `wdata0`, `wdata1`  in  8  write data, requester 0 / 1.
- `waddr0`, `waddr1`  in  8  write byte address, requester 0 / 1.
- `gnt`  out  2  one-hot grant, or 0.
- `wready`  out  2  write accepted this cycle (equals `gnt` while in WRITE).
- `sc_write_en`  out  1  to `strip_controller.write_en`.
- `sc_write_data`  out  8  to `strip_controller.write_data`.
- `sc_write_addr`  out  8  to `strip_controller.write_addr`.
- `sc_flush`  out  1  to `strip_controller.flush`.
- `sc_flushing`  in  1  from `strip_controller.flushing`.
- `busy`  out  1  state ≠ IDLE.
- `frame_count`  out  16  frames flushed; wraps at 16'hFFFF→0.
- `err_addr`  out  1  sticky: an out-of-range write was dropped.

## Operation
- States: IDLE, WRITE, FLUSH_REQ, FLUSHING, LATCH.
- IDLE: if `req != 0`, choose winner via round-robin pointer (pointer holds the last-served index; the other requester wins ties); after reset requester 0 wins ties. → WRITE with `gnt[winner]=1`.
- WRITE: `wready = gnt`. On `wvalid[g] & wready[g]`: if `waddr_g < NUM_BYTES`, register `sc_write_en=1`, data, addr; otherwise drop and set `err_addr`. Writes from the non-grantee are ignored. Pointer updates to g on exit from WRITE.
  - `done[g]` → FLUSH_REQ (a write in the same cycle is still forwarded).
  - `req[g]` low without `done[g]` → abort to IDLE; no flush, `frame_count` unchanged.
  - `done` wins over a simultaneous `req` drop.
- FLUSH_REQ: `sc_flush=1`, `gnt=0`; hold until `sc_flushing=1`, → FLUSHING.
- FLUSHING: `sc_flush=0`; on `sc_flushing=0` → LATCH, load counter with `LATCH_CYCLES-1`, increment `frame_count`.
- LATCH: decrement each cycle; at 0 → IDLE.
- `err_addr` clears only on reset.

## Timing
- Reset (async, `reset=0`): state IDLE, pointer = 1, `gnt`, `wready`, `sc_write_en`, `sc_write_data`, `sc_write_addr`, `sc_flush`, `busy`, `frame_count`, `err_addr` all 0. Reset mid-frame abandons the frame; the strip is not flushed.
- All outputs registered. `gnt` rises the cycle after `req` is sampled in IDLE.
- `sc_write_*` lag the accepted write by exactly 1 cycle; `sc_write_en` is a 1-cycle pulse per write; back-to-back writes are sustained at 1 per cycle.
- `sc_flush` rises the cycle after `done` is sampled; falls the cycle after `sc_flushing=1` is sampled.
- Minimum gap from `sc_flushing` falling to the next `gnt`: `LATCH_CYCLES + 1` cycles.
- `req`, `wvalid`, `done` from non-granted requesters are ignored except `req` in IDLE.

## Structure
- Package `strip_pkg`: state enum `sched_state_t`, constant `BYTES_PER_LED = 3`; shared with `strip_controller` and its bench.
- Sub-module `strip_rr_arbiter`: 2-way round-robin pick from `req` and pointer; combinational winner plus registered pointer update on `update` strobe.
- The latch counter and `frame_count` stay inline.

## Test plan
- Single frame: `NUM_BYTES=3`; req0, writes 0x11@0, 0x22@1, 0x33@2, done0 → three `sc_write_en` pulses with matching data/addr, one cycle late; `sc_flush` until `sc_flushing`; `frame_count=1`.
- Contention: req=2'b11 from reset → gnt=01 first; after its frame and latch → gnt=10; both still requesting → gnt=01 again.
- Latch gap: `LATCH_CYCLES=8`, req1 held → next `gnt` exactly 9 cycles after `sc_flushing` falls.
- Out-of-range: waddr0=3 with `NUM_BYTES=3` → no `sc_write_en`, `err_addr=1` and stays high through later frames.
- Abort/reset: req0 drops mid-WRITE → IDLE, no `sc_flush`, `frame_count` unchanged; `reset=0` during FLUSHING → all outputs 0 immediately, IDLE on release.
